// File: rtl/demux_pkg.sv
// Shared types and constants for the demux frame sequencer.
package demux_pkg;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Demux geometry
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    // Default frame shape
    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_GAP_CYCLES = 1;

endpackage : demux_pkg

// File: rtl/demux_frame_sequencer_if.sv
// Upstream valid/ready word channel feeding the frame sequencer.
interface demux_frame_sequencer_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_dest;

    // Word producer
    modport master (
        output in_valid,
        output in_data,
        output in_dest,
        input  in_ready
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dest,
        output in_ready
    );

endinterface : demux_frame_sequencer_if

// File: rtl/piso_shift_reg.sv
// Parallel-load, MSB-first shift register; msb exposes the current head bit.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load has priority over shift; zero fills from the bottom
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (shift) begin
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign msb = q_q[WIDTH-1];

endmodule : piso_shift_reg

// File: rtl/demux_frame_sequencer.sv
// Serializes accepted words MSB-first onto d with a stable sel and an idle gap between frames.
module demux_frame_sequencer
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_frame_sequencer_if.slave  up,
    output logic                    d,
    output logic [SEL_W-1:0]        sel,
    output logic                    frame_active,
    output logic                    frame_done
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned GAP_CNT_W = 4;

    state_e                 state_q;
    state_e                 state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_d;
    logic                   d_q;
    logic                   d_d;
    logic [SEL_W-1:0]       sel_q;
    logic [SEL_W-1:0]       sel_d;
    logic                   frame_active_q;
    logic                   frame_active_d;
    logic                   frame_done_q;
    logic                   frame_done_d;

    logic                   accept;
    logic                   bit_last;
    logic                   gap_last;
    logic                   sr_load;
    logic                   sr_shift;
    logic                   sr_msb;

    assign up.in_ready = (state_q == IDLE) && !rst;
    assign accept      = up.in_valid && up.in_ready;
    assign bit_last    = (bit_cnt_q == BIT_CNT_W'(WIDTH - 1));
    assign gap_last    = (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_last) begin
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; d/frame flags describe the following cycle
    always_comb begin
        d_d            = 1'b0;
        sel_d          = sel_q;
        frame_active_d = 1'b0;
        frame_done_d   = 1'b0;
        bit_cnt_d      = bit_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        sr_load        = 1'b0;
        sr_shift       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_load        = 1'b1;
                    d_d            = up.in_data[WIDTH-1];
                    sel_d          = up.in_dest;
                    frame_active_d = 1'b1;
                    bit_cnt_d      = '0;
                end
            end
            SHIFT: begin
                if (!bit_last) begin
                    sr_shift       = 1'b1;
                    d_d            = sr_msb;
                    frame_active_d = 1'b1;
                    frame_done_d   = (bit_cnt_q == BIT_CNT_W'(WIDTH - 2));
                    bit_cnt_d      = bit_cnt_q + BIT_CNT_W'(1);
                end else begin
                    gap_cnt_d      = '0;
                end
            end
            GAP: begin
                if (!gap_last) begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                d_d = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q            <= 1'b0;
            sel_q          <= '0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
        end else begin
            d_q            <= d_d;
            sel_q          <= sel_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    // Loaded pre-shifted: the word MSB goes straight to d, so the register head is always the next bit
    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   ({up.in_data[WIDTH-2:0], 1'b0}),
        .msb   (sr_msb)
    );

    assign d            = d_q;
    assign sel          = sel_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;

endmodule : demux_frame_sequencer

// File: doc/demux_frame_sequencer.md
Name: demux_frame_sequencer

Overview:
- Upstream feeder for the 1-to-8 demultiplexer.
- Accepts a parallel data word plus a 3-bit destination over a valid/ready handshake.
- Serializes the word MSB-first onto the demux data line `d`, holding `sel` stable for the whole frame.
- Inserts a programmable idle gap between frames so downstream per-channel logic sees clean frame boundaries.

Parameters:
- WIDTH, 8: payload bits per frame; legal range 2..32.
- GAP_CYCLES, 1: idle cycles inserted after each frame; legal range 0..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  sequencer can accept a word this cycle.
- in_data  input  WIDTH  word to serialize.
- in_dest  input  3  destination channel, 0..7.
- d  output  1  serial data to demux, registered.
- sel  output  3  demux select, registered.
- frame_active  output  1  high on every cycle `d` carries a payload bit.
- frame_done  output  1  one-cycle pulse coincident with the last payload bit.

Behaviour:
- Reset: rst sampled high at a clock edge forces the following, taking effect at that edge:
  - state=IDLE
  - d=0, sel=3'b000
  - frame_active=0, frame_done=0
  - shift register and bit counter = 0
- in_ready: combinational, equals (state==IDLE) && !rst.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - d=0, frame_active=0, sel holds its last value.
  - If in_valid && in_ready at an edge: latch in_data into the shift register, latch in_dest, go to SHIFT.
  - in_data/in_dest are ignored when no handshake occurs.
- SHIFT:
  - Lasts exactly WIDTH cycles.
  - On cycle k (k=0..WIDTH-1), registered outputs are d=in_data[WIDTH-1-k], sel=latched dest, frame_active=1.
  - frame_done=1 only on k=WIDTH-1.
  - After the last bit: go to GAP if GAP_CYCLES>0, else go to IDLE.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - d=0, frame_active=0, sel holds the frame's dest.
  - Then go to IDLE.
- Latency: the first payload bit appears on d in the cycle immediately after the accepting edge (1-cycle latency).
- Throughput: one frame per WIDTH+GAP_CYCLES+1 cycles, including the IDLE accept cycle.
- sel stability:
  - sel changes only on the edge that enters SHIFT.
  - It never changes while frame_active=1, so there are no glitches onto the wrong demux output.
- Bit counter width: $clog2(WIDTH)+1. Gap counter width: 4 bits. No wrap-around in either; counters reload on state entry.
- Back-to-back input: in_valid held high is accepted once per IDLE visit; no word is dropped or duplicated.
- Reset mid-frame (rst during SHIFT or GAP):
  - The frame is aborted.
  - Outputs are zero after that edge, with no frame_done pulse.
  - The latched word is discarded.
  - in_ready=0 during the rst cycle, then 1.
- Reset and in_valid in the same cycle: reset wins, no accept.
- in_dest is truncated to 3 bits by the port width; all 8 values are legal.

Decomposition:
- Shared package `demux_pkg`:
  - State enum (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2).
  - NUM_CH=8 and SEL_W=3 constants.
  - Default WIDTH/GAP_CYCLES constants.
- One natural sub-module, `piso_shift_reg`:
  - WIDTH-bit parallel-load, MSB-first shift register with load/shift enables.
  - The FSM and counters stay in the top module.

Test Plan:
- Reset release, then in_valid=1, in_data=8'hA5, in_dest=3 → d sequence 1,0,1,0,0,1,0,1 over cycles 1..8 after accept; sel=3 throughout; frame_active high for 8 cycles; frame_done on cycle 8 only.
- Back-to-back: words 8'hFF/dest 0 then 8'h01/dest 7 with in_valid held high (GAP_CYCLES=1) → frames 10 cycles apart; sel changes 0→7 only when the second frame starts; one gap cycle with d=0 between frames.
- GAP_CYCLES=0, WIDTH=4, words 4'h9 and 4'h6 → exactly one IDLE cycle between frames (in_ready=1 there); d=1,0,0,1,(0 idle),0,1,1,0.
- Reset mid-frame: assert rst on the 4th bit of 8'hC3 → d, frame_active and sel are 0 next cycle; no frame_done; next word 8'h80/dest 5 serializes cleanly.
- Handshake stall: in_valid=0 for 5 cycles in IDLE with in_data toggling → d stays 0, frame_active=0, no state change; in_ready stays 1.
- Sweep in_dest 0..7 with in_data=8'h01 → each frame ends with d=1 on its last bit under the matching sel; a scoreboard confirms exactly one frame per destination.
